// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI master shift engine
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  function automatic int len_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period timer producing an SCLK edge strobe and a leading/trailing flag
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic edge_o,
  output logic lead_o
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic lead_q, lead_d;
  assign edge_o = en_i && cnt_q == LAST;
  assign lead_o = lead_q;
  // Count clocks within a half-period; the lead flag flips per edge and rearms while cleared
  always_comb begin
    cnt_d = (!en_i || edge_o) ? '0 : cnt_q + CW'(1);
    lead_d = (!en_i || clr_i) ? 1'b1 : lead_q ^ edge_o;
  end
  // Timer state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lead_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      lead_q <= lead_d;
    end
  end
endmodule

// File: rtl/spi_shift_master.sv
// spi_shift_master: full-duplex SPI master with programmable length, bit order and CPOL/CPHA
module spi_shift_master
  import spi_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int CLK_DIV = 4,
  localparam int LEN_W = len_w(DATA_SIZE)
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_start,
  input  logic [DATA_SIZE-1:0] I_data,
  input  logic [LEN_W-1:0]     I_len,
  input  logic                 I_lsb_first,
  input  logic                 I_cpol,
  input  logic                 I_cpha,
  input  logic                 I_sdi,
  output logic                 O_sclk,
  output logic                 O_csb,
  output logic                 O_sdo,
  output logic                 O_busy,
  output logic                 O_done,
  output logic [DATA_SIZE-1:0] O_data
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_SIZE);
  state_e state_q, state_d;
  logic [DATA_SIZE-1:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d, msb_word, tx_word, rev;
  logic [LEN_W-1:0] len_q, len_d, bit_q, bit_d, len_in;
  logic lsb_q, lsb_d, cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d, sdo_q, sdo_d, done_q, done_d;
  logic edge_s, lead_s, last_s;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i (I_clk),
    .rst_i (I_rst),
    .en_i  (state_q != IDLE),
    .clr_i (state_q == SETUP),
    .edge_o(edge_s),
    .lead_o(lead_s)
  );
  assign O_sclk = sclk_q;
  assign O_csb = state_q == IDLE;
  assign O_sdo = sdo_q && state_q != IDLE;
  assign O_busy = state_q != IDLE;
  assign O_done = done_q;
  assign O_data = data_q;
  // Next-state and datapath: the TX word is arranged so the next bit to send is always at bit 0
  always_comb begin
    len_in = I_len > MAX_LEN ? MAX_LEN : I_len;
    msb_word = I_data << (MAX_LEN - len_in);
    for (int i = 0; i < DATA_SIZE; i++) rev[i] = msb_word[DATA_SIZE-1-i];
    tx_word = I_lsb_first ? I_data : rev;
    last_s = edge_s && !lead_s && bit_q == len_q - LEN_W'(1);
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    data_d = data_q;
    len_d = len_q;
    bit_d = bit_q;
    lsb_d = lsb_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    sclk_d = sclk_q;
    sdo_d = sdo_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = I_cpol;
        if (I_start && len_in != '0) begin
          state_d = SETUP;
          len_d = len_in;
          lsb_d = I_lsb_first;
          cpol_d = I_cpol;
          cpha_d = I_cpha;
          bit_d = '0;
          rx_d = '0;
          sdo_d = !I_cpha && tx_word[0];
          tx_d = I_cpha ? tx_word : tx_word >> 1;
        end
      end
      SETUP: state_d = edge_s ? SHIFT : SETUP;
      SHIFT: if (edge_s) begin
        sclk_d = ~sclk_q;
        if (lead_s != cpha_q) rx_d = lsb_q ? {I_sdi, rx_q[DATA_SIZE-1:1]} : {rx_q[DATA_SIZE-2:0], I_sdi};
        if (lead_s == cpha_q && !last_s) begin
          sdo_d = tx_q[0];
          tx_d = tx_q >> 1;
        end
        bit_d = lead_s ? bit_q : bit_q + LEN_W'(1);
        state_d = last_s ? HOLD : SHIFT;
      end
      HOLD: if (edge_s) begin
        state_d = IDLE;
        done_d = 1'b1;
        data_d = lsb_q ? rx_q >> (MAX_LEN - len_q) : rx_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= IDLE;
      tx_q <= '0;
      rx_q <= '0;
      data_q <= '0;
      len_q <= '0;
      bit_q <= '0;
      lsb_q <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sclk_q <= 1'b0;
      sdo_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      data_q <= data_d;
      len_q <= len_d;
      bit_q <= bit_d;
      lsb_q <= lsb_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      sclk_q <= sclk_d;
      sdo_q <= sdo_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_spi_shift_master.sv
// tb_spi_shift_master: scoreboard-driven directed test of the SPI master shift engine
module tb_spi_shift_master;
  import spi_pkg::*;
  localparam int DS = 8;
  localparam int CD = 2;
  localparam int LW = $clog2(DS) + 1;
  typedef struct {
    logic [DS-1:0] rx;
    logic [31:0]   seq;
    int            n;
    int            done_cyc;
    logic          cpha;
  } txn_t;
  logic clk = 0, rst = 1, start = 0, lsb = 0, cpol = 0, cpha = 0, loop = 1;
  logic [DS-1:0] data = '0;
  logic [LW-1:0] len = '0;
  logic [31:0] pat = '0;
  logic sclk, csb, sdo, busy, done, sdi;
  logic [DS-1:0] rdata;
  int cyc = 0, edges = 0, samples = 0, n_chk = 0, n_fail = 0;
  logic [31:0] obs_seq = '0;
  logic prev_sclk = 0;
  txn_t sb[$];

  spi_shift_master #(.DATA_SIZE(DS), .CLK_DIV(CD)) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_data(data), .I_len(len),
    .I_lsb_first(lsb), .I_cpol(cpol), .I_cpha(cpha), .I_sdi(sdi),
    .O_sclk(sclk), .O_csb(csb), .O_sdo(sdo), .O_busy(busy), .O_done(done), .O_data(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sdi = loop ? sdo : pat[samples[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bit sequence on SDO and the received word, from the transfer parameters alone
  function automatic txn_t mk(input logic [DS-1:0] d, input int l, input logic lsb_f, input logic pha,
                              input logic lb, input logic [31:0] p, input int k);
    txn_t t;
    logic r;
    t.n = l > DS ? DS : l;
    t.seq = '0;
    t.rx = '0;
    t.cpha = pha;
    t.done_cyc = k + (2 * t.n + 2) * CD;
    for (int j = 0; j < t.n; j++) begin
      r = lsb_f ? d[j] : d[t.n-1-j];
      t.seq = {t.seq[30:0], r};
      if (!lb) r = p[j];
      if (lsb_f) t.rx[j] = r;
      else t.rx[t.n-1-j] = r;
    end
    return t;
  endfunction

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    check("done_seen", done, 1);
  endtask

  task automatic xfer(input logic [DS-1:0] d, input int l, input logic lsb_f, input logic [1:0] mode,
                      input logic lb, input logic [31:0] p);
    data = d;
    len = LW'(l);
    lsb = lsb_f;
    {cpol, cpha} = mode;
    loop = lb;
    pat = p;
    @(negedge clk);
    start = 1;
    sb.push_back(mk(d, l, lsb_f, mode[0], lb, p, cyc + 1));
    @(negedge clk);
    start = 0;
    check("busy_on_start", busy, 1);
    check("csb_on_start", csb, 0);
    check("sclk_idle_on_start", sclk, mode[1]);
    wait_done();
  endtask

  // Monitor: collects SDO at every slave sampling edge and scores each completed transfer
  always @(negedge clk) begin
    txn_t t;
    if (done) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        check("rx_data", rdata, t.rx);
        check("done_cycle", cyc, t.done_cyc);
        check("sclk_pulses", samples, t.n);
        check("sdo_seq", obs_seq, t.seq);
        check("csb_at_done", csb, 1);
        check("busy_at_done", busy, 0);
      end
    end
    if (csb) begin
      edges = 0;
      samples = 0;
      obs_seq = '0;
    end else if (sclk !== prev_sclk) begin
      edges++;
      if (edges[0] != (sb.size() > 0 ? sb[0].cpha : 1'b0)) begin
        obs_seq = {obs_seq[30:0], sdo};
        samples++;
      end
    end
    prev_sclk = sclk;
  end

  initial begin
    int n;
    logic idle_ok;
    #1;
    check("rst_sclk", sclk, 0);
    check("rst_csb", csb, 1);
    check("rst_sdo", sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", rdata, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    xfer(8'hA5, 8, 1'b0, MODE0, 1'b1, 32'h0);
    xfer(8'h3C, 8, 1'b1, MODE3, 1'b0, 32'hC3);
    xfer(8'h13, 5, 1'b0, MODE0, 1'b1, 32'h0);
    xfer(8'h5A, 12, 1'b0, MODE1, 1'b1, 32'h0);
    // zero length must be ignored entirely
    data = 8'hFF;
    len = '0;
    @(negedge clk);
    start = 1;
    idle_ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (!csb || busy) idle_ok = 0;
    end
    start = 0;
    check("len0_idle", idle_ok, 1);
    // back-to-back: start held high, second word set up while the first is in flight
    data = 8'h96;
    len = 4'd8;
    lsb = 0;
    {cpol, cpha} = MODE2;
    loop = 1;
    @(negedge clk);
    start = 1;
    sb.push_back(mk(8'h96, 8, 1'b0, 1'b0, 1'b1, 32'h0, cyc + 1));
    @(negedge clk);
    data = 8'h2D;
    len = 4'd6;
    lsb = 1;
    cpha = 1;
    wait_done();
    cpha = 0;
    check("b2b_csb_gap", csb, 1);
    sb.push_back(mk(8'h2D, 6, 1'b1, 1'b0, 1'b1, 32'h0, cyc + 1));
    @(negedge clk);
    check("b2b_csb_low_again", csb, 0);
    check("b2b_busy", busy, 1);
    start = 0;
    wait_done();
    // reset in the middle of a transfer
    data = 8'hF0;
    len = 4'd8;
    lsb = 0;
    {cpol, cpha} = MODE2;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0;
    while (edges < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_edges_reached", edges >= 3, 1);
    rst = 1;
    #1;
    check("mid_rst_csb", csb, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_sdo", sdo, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", rdata, 0);
    @(negedge clk);
    rst = 0;
    repeat (60) @(negedge clk);
    check("post_rst_data", rdata, 0);
    check("post_rst_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
